// File: rtl/ks_serial_adder.sv
// Byte-serial adder/subtractor: one 8-bit slice per clock through a Kogge-Stone
// carry network, with results registered only when the whole word is complete.
module ks_serial_adder #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] a,
    input  logic [8*NUM_BYTES-1:0] b,
    input  logic                   sub,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [8*NUM_BYTES-1:0] sum,
    output logic                   cout,
    output logic                   overflow,
    output logic                   zero
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic            r_carry;
    logic [IW-1:0]   r_idx;

    logic            w_lastByte;
    logic [7:0]      w_aByte;
    logic [7:0]      w_bByte;
    logic [7:0]      w_p;
    logic [7:0]      w_g0;
    logic [7:0]      w_g1;
    logic [7:2]      w_p1;
    logic [7:0]      w_g2;
    logic [7:4]      w_p2;
    logic [7:0]      w_c;
    logic [7:0]      w_sumByte;
    logic [W-1:0]    w_fullSum;

    assign busy       = (r_state == BUSY);
    assign w_lastByte = (r_idx == IW'(NUM_BYTES - 1));
    assign w_aByte    = r_a[{r_idx, 3'b000} +: 8];
    assign w_bByte    = r_b[{r_idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (start) w_stateNext = BUSY;
            BUSY:    if (w_lastByte) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Running carry is folded into bit 0 generate so the prefix tree yields true carries.
    always_comb begin
        w_p  = w_aByte ^ w_bByte;
        w_g0 = w_aByte & w_bByte;
        w_g0[0] = w_g0[0] | (w_p[0] & r_carry);

        w_g1 = w_g0;
        for (int k = 1; k < 8; k++) begin
            w_g1[k] = w_g0[k] | (w_p[k] & w_g0[k-1]);
        end
        for (int k = 2; k < 8; k++) begin
            w_p1[k] = w_p[k] & w_p[k-1];
        end

        w_g2 = w_g1;
        for (int k = 2; k < 8; k++) begin
            w_g2[k] = w_g1[k] | (w_p1[k] & w_g1[k-2]);
        end
        for (int k = 4; k < 8; k++) begin
            w_p2[k] = w_p1[k] & w_p1[k-2];
        end

        w_c = w_g2;
        for (int k = 4; k < 8; k++) begin
            w_c[k] = w_g2[k] | (w_p2[k] & w_g2[k-4]);
        end

        w_sumByte = w_p ^ {w_c[6:0], r_carry};
        w_fullSum = r_acc;
        w_fullSum[{r_idx, 3'b000} +: 8] = w_sumByte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_a     <= a;
                    r_b     <= sub ? ~b : b;
                    r_carry <= sub | cin;
                    r_idx   <= '0;
                end
            end else begin
                r_acc   <= w_fullSum;
                r_carry <= w_c[7];
                r_idx   <= r_idx + 1'b1;
                if (w_lastByte) begin
                    sum      <= w_fullSum;
                    cout     <= w_c[7];
                    overflow <= w_c[7] ^ w_c[6];
                    zero     <= (w_fullSum == '0);
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ks_serial_adder.sv
// Scoreboard bench for ks_serial_adder: expected results come from a word-level
// arithmetic model, queued at issue time and popped when done pulses.
module tb_ks_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    ks_serial_adder #(.NUM_BYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                   input logic isub, input logic icin);
        logic [31:0] bb;
        logic [32:0] r;
        exp_t        e;
        bb  = isub ? ~ib : ib;
        r   = {1'b0, ia} + {1'b0, bb} + {32'd0, (isub ? 1'b1 : icin)};
        e.s = r[31:0];
        e.c = r[32];
        e.v = (ia[31] == bb[31]) && (r[31] != ia[31]);
        e.z = (r[31:0] == 32'd0);
        return e;
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic icin);
        a     = ia;
        b     = ib;
        sub   = isub;
        cin   = icin;
        start = 1'b1;
        sbq.push_back(model(ia, ib, isub, icin));
    endtask

    // Inputs are scrambled while busy so any leakage into the result shows up.
    task automatic wait_done(output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        if (busy) busyCnt++;
        while (!done && lat < 20) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (busy) busyCnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 32'hDEADBEEF; b = 32'h1; sub = 1'b0; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (sum !== 32'd0) begin bad++; $display("[TB] FAIL reset_sum got=%h want=0", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout got=%b want=0", cout); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero got=%b want=1", zero); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_vectors();
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic        vs[6];
        logic        vc[6];
        int          lat;
        int          bc;
        exp_t        e;
        va = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'd5, 32'h80000000};
        vb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h0, 32'd7, 32'h00000001};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vs[i], vc[i]);
            wait_done(lat, bc);
            total++; if (lat !== 5) begin bad++; $display("[TB] FAIL vec%0d_latency got=%0d want=5", i, lat); end
            total++; if (bc !== 4) begin bad++; $display("[TB] FAIL vec%0d_busycycles got=%0d want=4", i, bc); end
            e = sbq.pop_front();
            total++; if (sum !== e.s) begin bad++; $display("[TB] FAIL vec%0d_sum got=%h want=%h", i, sum, e.s); end
            total++; if (cout !== e.c) begin bad++; $display("[TB] FAIL vec%0d_cout got=%b want=%b", i, cout, e.c); end
            total++; if (overflow !== e.v) begin bad++; $display("[TB] FAIL vec%0d_ovf got=%b want=%b", i, overflow, e.v); end
            total++; if (zero !== e.z) begin bad++; $display("[TB] FAIL vec%0d_zero got=%b want=%b", i, zero, e.z); end
            @(posedge clk); #1;
            total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL vec%0d_done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] prev;
        int          lat;
        int          extra;
        exp_t        e;
        prev = sum;
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        @(posedge clk); #1;
        lat++;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b1; start = 1'b1;
        total++; if (sum !== prev) begin bad++; $display("[TB] FAIL ign_sum_hidden got=%h want=%h", sum, prev); end
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL ign_latency got=%0d want=5", lat); end
        e = sbq.pop_front();
        total++; if (sum !== e.s) begin bad++; $display("[TB] FAIL ign_sum got=%h want=%h", sum, e.s); end
        total++; if (cout !== e.c) begin bad++; $display("[TB] FAIL ign_cout got=%b want=%b", cout, e.c); end
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy || done) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("[TB] FAIL ign_spurious_op got=%0d want=0", extra); end
        total++; if (sum !== e.s) begin bad++; $display("[TB] FAIL ign_sum_hold got=%h want=%h", sum, e.s); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   bc;
        exp_t e;
        issue(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL b2b_first_latency got=%0d want=5", lat); end
        e = sbq.pop_front();
        total++; if (sum !== e.s) begin bad++; $display("[TB] FAIL b2b_first_sum got=%h want=%h", sum, e.s); end
        total++; if (zero !== e.z) begin bad++; $display("[TB] FAIL b2b_first_zero got=%b want=%b", zero, e.z); end
        issue(32'h00010000, 32'h00020001, 1'b1, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL b2b_second_latency got=%0d want=5", lat); end
        e = sbq.pop_front();
        total++; if (sum !== e.s) begin bad++; $display("[TB] FAIL b2b_second_sum got=%h want=%h", sum, e.s); end
        total++; if (cout !== e.c) begin bad++; $display("[TB] FAIL b2b_second_cout got=%b want=%b", cout, e.c); end
        total++; if (overflow !== e.v) begin bad++; $display("[TB] FAIL b2b_second_ovf got=%b want=%b", overflow, e.v); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int   seen;
        exp_t e;
        issue(32'h01020304, 32'h10203040, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        e = sbq.pop_front();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy got=%b want=0", busy); end
        total++; if (sum !== 32'd0) begin bad++; $display("[TB] FAIL rmid_sum got=%h want=0 (aborted %h)", sum, e.s); end
        total++; if (zero !== 1'b1) begin bad++; $display("[TB] FAIL rmid_zero got=%b want=1", zero); end
        seen = 0;
        repeat (8) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL rmid_done_after_abort got=%0d want=0", seen); end
        total++; if (sum !== 32'd0) begin bad++; $display("[TB] FAIL rmid_sum_hold got=%h want=0", sum); end
    endtask

    task automatic test_random();
        int   lat;
        int   bc;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(lat, bc);
            total++; if (lat !== 5) begin bad++; $display("[TB] FAIL rnd%0d_latency got=%0d want=5", i, lat); end
            e = sbq.pop_front();
            total++; if ({sum, cout, overflow, zero} !== {e.s, e.c, e.v, e.z}) begin
                bad++;
                $display("[TB] FAIL rnd%0d_result got=%h/%b/%b/%b want=%h/%b/%b/%b",
                         i, sum, cout, overflow, zero, e.s, e.c, e.v, e.z);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        total++; if (sbq.size() !== 0) begin bad++; $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ks_serial_adder.md
KS_SERIAL_ADDER -- requirements
Module: ks_serial_adder

Interface
REQ-001 The module SHALL have parameter NUM_BYTES, default 4, giving the number of 8-bit slices per operation; operand width W = 8*NUM_BYTES.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1, request to begin an operation; sampled only when idle.
REQ-005 The module SHALL have port a, input, W, operand A; captured when start is accepted.
REQ-006 The module SHALL have port b, input, W, operand B; captured when start is accepted.
REQ-007 The module SHALL have port sub, input, 1, 1 = compute a-b, 0 = compute a+b+cin; captured when start is accepted.
REQ-008 The module SHALL have port cin, input, 1, carry-in for add; ignored when sub=1.
REQ-009 The module SHALL have port busy, output, 1, high while byte slices are being processed.
REQ-010 The module SHALL have port done, output, 1, single-cycle pulse marking valid results.
REQ-011 The module SHALL have port sum, output, W, result.
REQ-012 The module SHALL have port cout, output, 1, carry out of the MSB; for sub this is the no-borrow flag.
REQ-013 The module SHALL have port overflow, output, 1, two's-complement overflow.
REQ-014 The module SHALL have port zero, output, 1, high when sum == 0.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-016 In IDLE, start=1 SHALL be accepted at the clock edge, with these captures:
- a stored in a holding register;
- b stored as b when sub=0, as ~b when sub=1;
- running carry set to (sub ? 1 : cin);
- byte index set to 0;
- state moves to BUSY.
REQ-017 In BUSY, each clock edge SHALL process byte i = byte index as follows:
- g[j] = A_i[j] & B_i[j] and p[j] = A_i[j] ^ B_i[j];
- g[0] replaced by g[0] | (p[0] & carry);
- carries computed by the team's 8-bit Kogge-Stone prefix network (Carry[k] = group generate of bits 0..k);
- sum byte i = p ^ {Carry[6:0], carry};
- running carry updated to Carry[7].
REQ-018 The byte index SHALL increment by 1 per BUSY cycle; after byte NUM_BYTES-1, state SHALL return to IDLE at that same edge.
REQ-019 busy SHALL equal (state == BUSY): high for exactly NUM_BYTES cycles, beginning the cycle after start is accepted.
REQ-020 At the final-byte edge, the block SHALL register results and set done=1 for exactly one cycle:
- cout = final Carry[7];
- overflow = Carry[7] ^ Carry[6] of the final byte;
- zero = (complete sum == 0).
REQ-021 Latency SHALL be fixed: done is high in cycle NUM_BYTES+1, counting the start-accept cycle as cycle 0.
REQ-022 sum, cout, overflow and zero SHALL change only at the final-byte edge or on reset, and SHALL hold their values until the next operation completes.
REQ-023 Partial sum bytes SHALL NOT be visible on sum while busy; sum shows the previous result until completion.
REQ-024 start SHALL be ignored while busy=1; a, b, sub and cin changes while busy SHALL have no effect.
REQ-025 start=1 in the same cycle as done=1 SHALL be accepted, since the FSM is IDLE then, giving back-to-back operations with no idle gap.
REQ-026 Arithmetic SHALL be modulo 2^W; there is no saturation.

Reset
REQ-027 rst=1 at a clock edge SHALL, with priority over start and any in-flight operation:
- force state to IDLE;
- clear busy, done, sum, cout, overflow and the running carry and byte index to 0;
- set zero to 1.
REQ-028 An operation aborted by reset SHALL never assert done, and no partial result SHALL appear on outputs.

Verification
REQ-029 Add, NUM_BYTES=4: a=0x000000FF, b=0x00000001, sub=0, cin=0 -> sum=0x00000100, cout=0, overflow=0, zero=0; busy high 4 cycles; done in cycle 5.
REQ-030 Add wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, zero=1, overflow=0.
REQ-031 Add overflow and cin:
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, overflow=1, cout=0;
- a=0, b=0, cin=1 -> sum=0x00000001.
REQ-032 Subtract:
- a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0;
- a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
REQ-033 Handshake:
- start pulsed mid-operation -> ignored and the original result unchanged;
- start asserted in the done cycle -> second result's done arrives exactly 5 cycles later.
REQ-034 Reset mid-operation: rst at the 2nd BUSY cycle -> next cycle busy=0, sum=0, zero=1, and done stays 0 until a new start.
